// File: rtl/wb_sram_target_if.sv
// Wishbone B4 link between a master (e.g. a master BFM) and wb_sram_target.
//   ADR    byte address          DAT_W  write data        DAT_R  read data
//   CYC    bus cycle valid       STB    strobe            WE     1=write
//   SEL    byte-lane enables     CTI    cycle type id     BTE    burst type
//   ACK    normal termination    ERR    error termination
// Modports: master drives the request side, slave drives DAT_R/ACK/ERR.
interface wb_sram_target_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic [AW-1:0]   ADR;
  logic [DW-1:0]   DAT_W;
  logic [DW-1:0]   DAT_R;
  logic            CYC;
  logic            STB;
  logic            WE;
  logic [DW/8-1:0] SEL;
  logic [2:0]      CTI;
  logic [1:0]      BTE;
  logic            ACK;
  logic            ERR;

  modport master (
    output ADR, DAT_W, CYC, STB, WE, SEL, CTI, BTE,
    input  DAT_R, ACK, ERR
  );

  modport slave (
    input  ADR, DAT_W, CYC, STB, WE, SEL, CTI, BTE,
    output DAT_R, ACK, ERR
  );
endinterface

// File: rtl/wb_sram_target.sv
// Wishbone B4 slave memory model. Completes classic cycles and registered-feedback
// incrementing/wrapping bursts against an internal word array. A programmable number of
// wait states precedes the first ACK/ERR of each access; words at or beyond MEM_WORDS
// answer with ERR.
// Ports:
//   clk   clock, all logic on posedge
//   rstn  synchronous active-low reset (memory contents are not cleared)
//   bus   wb_sram_target_if slave modport; interface widths must match
//         WB_ADDR_WIDTH / WB_DATA_WIDTH
module wb_sram_target #(
  parameter int unsigned WB_ADDR_WIDTH = 32,
  parameter int unsigned WB_DATA_WIDTH = 32,
  parameter int unsigned MEM_WORDS     = 1024,
  parameter int unsigned WAIT_STATES   = 0
) (
  input  logic            clk,
  input  logic            rstn,
  wb_sram_target_if.slave bus
);

  localparam int unsigned SW  = WB_DATA_WIDTH / 8;
  localparam int unsigned LSB = $clog2(SW);
  localparam int unsigned IW  = WB_ADDR_WIDTH - LSB;
  localparam int unsigned MW  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [2:0] CTI_INCR = 3'b010;

  logic [WB_DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic [1:0]               state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [IW-1:0]            ptr_q, ptr_d;
  logic                     ack_q, ack_d;
  logic                     err_q, err_d;
  logic [WB_DATA_WIDTH-1:0] dat_q, dat_d;

  logic                     cyc_stb;
  logic [IW-1:0]            adr_word;
  logic [IW-1:0]            ptr_next;
  logic [IW-1:0]            resp_addr;
  logic                     resp_en;
  logic                     mem_we;
  logic [WB_DATA_WIDTH-1:0] rd_word;

  // Sub-word address bits carry no information for a word-wide target.
  logic unused_adr_lsb;
  assign unused_adr_lsb = ^bus.ADR[LSB-1:0];

  assign cyc_stb  = bus.CYC & bus.STB;
  assign adr_word = bus.ADR[WB_ADDR_WIDTH-1:LSB];

  function automatic logic in_range(input logic [IW-1:0] addr);
    return 64'(addr) < 64'(MEM_WORDS);
  endfunction

  function automatic logic [WB_DATA_WIDTH-1:0] merge_lanes(
    input logic [WB_DATA_WIDTH-1:0] old_word,
    input logic [WB_DATA_WIDTH-1:0] new_word,
    input logic [SW-1:0]            sel
  );
    logic [WB_DATA_WIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < SW; i++) begin
      if (sel[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  // Burst pointer advance: wrap modes only bump the low bits, upper bits stay put.
  always_comb begin
    ptr_next = ptr_q;
    case (bus.BTE)
      2'b01:   ptr_next[1:0] = ptr_q[1:0] + 2'd1;
      2'b10:   ptr_next[2:0] = ptr_q[2:0] + 3'd1;
      2'b11:   ptr_next[3:0] = ptr_q[3:0] + 4'd1;
      default: ptr_next = ptr_q + IW'(1);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    dat_d     = '0;
    mem_we    = 1'b0;
    resp_en   = 1'b0;
    resp_addr = ptr_q;
    rd_word   = '0;

    case (state_q)
      S_IDLE: begin
        if (cyc_stb) begin
          ptr_d = adr_word;
          if (WAIT_STATES == 0) begin
            state_d   = S_RESP;
            resp_en   = 1'b1;
            resp_addr = adr_word;
          end else begin
            cnt_d   = 4'(WAIT_STATES);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!cyc_stb) begin
          // Master abandoned the access: no response at all.
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = S_RESP;
            resp_en = 1'b1;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        // A beat completes only when the master still holds CYC&STB during ACK.
        if (ack_q && cyc_stb) begin
          mem_we = bus.WE;
          if (bus.CTI == CTI_INCR) begin
            ptr_d     = ptr_next;
            resp_addr = ptr_next;
            resp_en   = 1'b1;
            state_d   = S_RESP;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (resp_en) begin
      if (in_range(resp_addr)) begin
        rd_word = mem[resp_addr[MW-1:0]];
        // Write-first bypass when the next beat reads the word being written now.
        if (mem_we && (resp_addr == ptr_q)) begin
          rd_word = merge_lanes(rd_word, bus.DAT_W, bus.SEL);
        end
        ack_d = 1'b1;
        dat_d = rd_word;
      end else begin
        err_d = 1'b1;
        // A burst that runs off the array ends here; ERR always returns to IDLE.
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  // ack_q is only ever set for an in-range word, so the index is valid here.
  always_ff @(posedge clk) begin
    if (rstn && mem_we) begin
      for (int i = 0; i < SW; i++) begin
        if (bus.SEL[i]) mem[ptr_q[MW-1:0]][8*i +: 8] <= bus.DAT_W[8*i +: 8];
      end
    end
  end

  assign bus.ACK   = ack_q;
  assign bus.ERR   = err_q;
  assign bus.DAT_R = dat_q;

endmodule

// File: tb/tb_wb_sram_target.sv
module tb_wb_sram_target;

  localparam int unsigned WS = 2;
  localparam int unsigned MW = 64;

  typedef struct {
    bit          err;
    bit          chk;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rstn;

  wb_sram_target_if #(.AW(32), .DW(32)) bus ();

  wb_sram_target #(
    .WB_ADDR_WIDTH(32),
    .WB_DATA_WIDTH(32),
    .MEM_WORDS    (MW),
    .WAIT_STATES  (WS)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        sb[$];
  logic [31:0] ref_mem [MW];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    else n_pass++;
  endtask

  // Word visited after a in a burst of type bte.
  function automatic int unsigned next_word(input int unsigned a, input logic [1:0] bte);
    int unsigned sz;
    if (bte == 2'b00) return a + 1;
    sz = 2 << bte;
    return (a / sz) * sz + ((a % sz) + 1) % sz;
  endfunction

  // Monitor: every ACK/ERR cycle consumes one expected response.
  always @(negedge clk) begin
    if (rstn && (bus.ACK || bus.ERR)) begin
      exp_t e;
      check("ack_err_exclusive", 32'(bus.ACK & bus.ERR), 32'd0);
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_response: got ack=%0b err=%0b expected none", bus.ACK, bus.ERR);
      end else begin
        e = sb.pop_front();
        check("resp_err", 32'(bus.ERR), 32'(e.err));
        check("resp_ack", 32'(bus.ACK), 32'(!e.err));
        if (e.chk) check("resp_data", bus.DAT_R, e.err ? 32'd0 : e.data);
      end
    end
  end

  // mode 0: random data/sel, 1: fixed data/sel, 2: random data with fixed sel.
  task automatic run_cycle(input bit we, input int unsigned start, input int unsigned nbeats,
                           input logic [1:0] bte, input bit chk, input int mode,
                           input logic [31:0] fdata, input logic [3:0] fsel);
    int unsigned a;
    int          k;
    bit          done;
    exp_t        e;
    logic [31:0] d;
    logic [3:0]  s;
    a    = start;
    done = 0;
    for (int b = 0; b < int'(nbeats) && !done; b++) begin
      d = (mode == 1) ? fdata : $urandom;
      s = (mode == 0) ? 4'($urandom) : fsel;
      // Only the first beat's ADR matters; later beats present junk.
      bus.ADR   = (b == 0) ? 32'(a * 4 + $urandom_range(0, 3)) : $urandom;
      bus.WE    = we;
      bus.DAT_W = d;
      bus.SEL   = s;
      bus.BTE   = bte;
      bus.CTI   = (nbeats == 1) ? 3'b000 : (b == int'(nbeats) - 1) ? 3'b111 : 3'b010;
      bus.CYC   = 1'b1;
      bus.STB   = 1'b1;
      e.err  = (a >= MW);
      e.chk  = chk;
      e.data = e.err ? 32'd0 : ref_mem[a];
      sb.push_back(e);
      if (b == 0) @(posedge clk);
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!(bus.ACK || bus.ERR) && k < 20);
      check(b == 0 ? "first_beat_latency" : "beat_latency", 32'(k),
            (b == 0) ? 32'(WS + 1) : 32'd1);
      if (!(bus.ACK || bus.ERR)) begin
        sb.delete();
        bus.CYC = 1'b0;
        bus.STB = 1'b0;
        return;
      end
      if (e.err) begin
        done = 1;
      end else if (we) begin
        for (int i = 0; i < 4; i++) if (s[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
      end
      a = next_word(a, bte);
      @(posedge clk);
      #1;
    end
    bus.CYC = 1'b0;
    bus.STB = 1'b0;
    @(negedge clk);
    check("idle_after_cycle", 32'({bus.ACK, bus.ERR}), 32'd0);
  endtask

  initial begin
    int unsigned w;
    bus.ADR = '0; bus.DAT_W = '0; bus.CYC = 0; bus.STB = 0; bus.WE = 0;
    bus.SEL = '0; bus.CTI = '0; bus.BTE = '0;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ack", 32'(bus.ACK), 32'd0);
    check("reset_err", 32'(bus.ERR), 32'd0);
    check("reset_dat_r", bus.DAT_R, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Fill the whole array with one linear burst so every later read has a known value.
    run_cycle(1, 0, MW, 2'b00, 0, 2, 32'd0, 4'hF);

    run_cycle(1, 4, 1, 2'b00, 1, 1, 32'hDEADBEEF, 4'hF);
    run_cycle(0, 4, 1, 2'b00, 1, 1, 32'd0, 4'h0);
    run_cycle(1, 8, 1, 2'b00, 1, 1, 32'h11223344, 4'hF);
    run_cycle(1, 8, 1, 2'b00, 1, 1, 32'hAABBCCDD, 4'h5);
    run_cycle(0, 8, 1, 2'b00, 1, 1, 32'd0, 4'h0);
    run_cycle(1, 9, 1, 2'b00, 1, 1, 32'h55555555, 4'h0);
    run_cycle(0, 9, 1, 2'b00, 1, 1, 32'd0, 4'h0);

    run_cycle(0, 4, 4, 2'b00, 1, 0, 32'd0, 4'h0);
    run_cycle(0, 6, 4, 2'b01, 1, 0, 32'd0, 4'h0);
    run_cycle(0, 13, 8, 2'b10, 1, 0, 32'd0, 4'h0);
    run_cycle(1, 20, 5, 2'b11, 1, 0, 32'd0, 4'h0);
    run_cycle(0, 16, 16, 2'b00, 1, 0, 32'd0, 4'h0);

    run_cycle(0, MW, 1, 2'b00, 1, 0, 32'd0, 4'h0);
    run_cycle(1, MW + 1, 1, 2'b00, 1, 1, 32'h12345678, 4'hF);
    run_cycle(1, MW - 2, 4, 2'b00, 1, 2, 32'd0, 4'hF);
    run_cycle(0, MW - 2, 2, 2'b00, 1, 0, 32'd0, 4'h0);

    // Master drops CYC while ACK is high: beat must not complete, no write.
    w = 30;
    bus.ADR = 32'(w * 4); bus.WE = 1; bus.DAT_W = 32'hCAFEF00D; bus.SEL = 4'hF;
    bus.CTI = 3'b000; bus.BTE = 2'b00; bus.CYC = 1; bus.STB = 1;
    sb.push_back('{err: 1'b0, chk: 1'b1, data: ref_mem[w]});
    @(posedge clk);
    for (int k = 0; k < 20 && !bus.ACK; k++) @(negedge clk);
    bus.CYC = 0; bus.STB = 0;
    @(negedge clk);
    check("cyc_drop_ack_low", 32'(bus.ACK), 32'd0);
    run_cycle(0, w, 1, 2'b00, 1, 0, 32'd0, 4'h0);

    // Reset while waiting: access aborted, memory intact.
    w = 31;
    bus.ADR = 32'(w * 4); bus.WE = 1; bus.DAT_W = 32'h0BADC0DE; bus.SEL = 4'hF;
    bus.CTI = 3'b000; bus.CYC = 1; bus.STB = 1;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("rst_wait_ack", 32'(bus.ACK), 32'd0);
    check("rst_wait_err", 32'(bus.ERR), 32'd0);
    bus.CYC = 0; bus.STB = 0;
    rstn = 1'b1;
    @(negedge clk);
    run_cycle(0, w, 1, 2'b00, 1, 0, 32'd0, 4'h0);

    for (int n = 0; n < 40; n++) begin
      run_cycle(1'($urandom), $urandom_range(0, MW + 3), $urandom_range(1, 8),
                2'($urandom), 1, 0, 32'd0, 4'h0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
